// File: rtl/decode_writeback_if.sv
// decode_writeback_if: bundles the fetch/execute/memory-facing signals of the
// decode/write-back stage.
//   master : upstream side; drives icode/rA/rB/cnd/valE/valM/wb_en and
//            observes the decoded IDs and operands.
//   slave  : the decode/write-back stage itself.
interface decode_writeback_if #(
    parameter int unsigned WIDTH = 64
);
    logic [3:0]       icode;
    logic [3:0]       rA;
    logic [3:0]       rB;
    logic             cnd;
    logic [WIDTH-1:0] valE;
    logic [WIDTH-1:0] valM;
    logic             wb_en;
    logic [3:0]       srcA;
    logic [3:0]       srcB;
    logic [3:0]       dstE;
    logic [3:0]       dstM;
    logic [WIDTH-1:0] valA;
    logic [WIDTH-1:0] valB;

    modport master (
        output icode, rA, rB, cnd, valE, valM, wb_en,
        input  srcA, srcB, dstE, dstM, valA, valB
    );

    modport slave (
        input  icode, rA, rB, cnd, valE, valM, wb_en,
        output srcA, srcB, dstE, dstM, valA, valB
    );
endinterface

// File: rtl/decode_writeback.sv
// decode_writeback: Y86-64 register-file stage for the sequential core.
// Decodes icode/rA/rB into srcA/srcB/dstE/dstM, reads valA/valB
// combinationally from a 15-entry register file, and writes valE/valM back
// on the rising clock edge when wb_en is high.
// Ports:
//   clk   : core clock, all state changes on posedge
//   rst_n : asynchronous active-low reset, clears R[0..14]
//   bus   : decode_writeback_if.slave (decode inputs, write-back data,
//           decoded IDs and operand outputs)
module decode_writeback #(
    parameter int unsigned WIDTH  = 64,
    parameter logic [3:0]  RSP_ID = 4'h4,
    parameter logic [3:0]  RNONE  = 4'hF
) (
    input  logic                clk,
    input  logic                rst_n,
    decode_writeback_if.slave   bus
);

    localparam logic [3:0] ICmov  = 4'h2;
    localparam logic [3:0] IIrmov = 4'h3;
    localparam logic [3:0] IRmmov = 4'h4;
    localparam logic [3:0] IMrmov = 4'h5;
    localparam logic [3:0] IOp    = 4'h6;
    localparam logic [3:0] ICall  = 4'h8;
    localparam logic [3:0] IRet   = 4'h9;
    localparam logic [3:0] IPush  = 4'hA;
    localparam logic [3:0] IPop   = 4'hB;

    logic [WIDTH-1:0] rf_q [0:14];
    logic [WIDTH-1:0] rf_d [0:14];

    logic [3:0] src_a;
    logic [3:0] src_b;
    logic [3:0] dst_e;
    logic [3:0] dst_m;

    // Register ID decode; halt, nop, jXX and unknown icodes fall to RNONE.
    always_comb begin
        src_a = RNONE;
        src_b = RNONE;
        dst_e = RNONE;
        dst_m = RNONE;
        case (bus.icode)
            ICmov: begin
                src_a = bus.rA;
                dst_e = bus.cnd ? bus.rB : RNONE;
            end
            IIrmov: begin
                dst_e = bus.rB;
            end
            IRmmov: begin
                src_a = bus.rA;
                src_b = bus.rB;
            end
            IMrmov: begin
                src_b = bus.rB;
                dst_m = bus.rA;
            end
            IOp: begin
                src_a = bus.rA;
                src_b = bus.rB;
                dst_e = bus.rB;
            end
            ICall: begin
                src_b = RSP_ID;
                dst_e = RSP_ID;
            end
            IRet: begin
                src_a = RSP_ID;
                src_b = RSP_ID;
                dst_e = RSP_ID;
            end
            IPush: begin
                src_a = bus.rA;
                src_b = RSP_ID;
                dst_e = RSP_ID;
            end
            IPop: begin
                src_a = RSP_ID;
                src_b = RSP_ID;
                dst_e = RSP_ID;
                dst_m = bus.rA;
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.srcA = src_a;
        bus.srcB = src_b;
        bus.dstE = dst_e;
        bus.dstM = dst_m;
        bus.valA = (src_a == RNONE) ? '0 : rf_q[src_a];
        bus.valB = (src_b == RNONE) ? '0 : rf_q[src_b];
    end

    // M port applied after E so it wins when both target the same register.
    always_comb begin
        rf_d = rf_q;
        if (bus.wb_en) begin
            if (dst_e != RNONE) begin
                rf_d[dst_e] = bus.valE;
            end
            if (dst_m != RNONE) begin
                rf_d[dst_m] = bus.valM;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 15; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            rf_q <= rf_d;
        end
    end

endmodule

// File: tb/tb_decode_writeback.sv
// Self-checking bench for decode_writeback: a model register file and
// decode model push expected values to a scoreboard queue as each stimulus
// is applied; the queue is drained against the DUT outputs between edges.
module tb_decode_writeback;

    localparam int unsigned W = 64;

    // Scoreboard entry kinds
    localparam int KSrcA = 0;
    localparam int KSrcB = 1;
    localparam int KDstE = 2;
    localparam int KDstM = 3;
    localparam int KValA = 4;
    localparam int KValB = 5;

    typedef struct {
        string       tag;
        int          kind;
        logic [63:0] exp;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    decode_writeback_if #(.WIDTH(W)) bus ();

    decode_writeback #(
        .WIDTH  (W),
        .RSP_ID (4'h4),
        .RNONE  (4'hF)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] ref_rf [0:14];
    exp_t        sb [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Model decode: derive which fields each instruction uses.
    function automatic void model_decode(input logic [3:0] ic, input logic [3:0] ra,
                                         input logic [3:0] rb, input logic c,
                                         output logic [3:0] sa, output logic [3:0] sbid,
                                         output logic [3:0] de, output logic [3:0] dm);
        bit a_uses_ra, a_uses_sp, b_uses_rb, b_uses_sp, e_uses_rb, e_uses_sp, m_uses_ra;
        a_uses_ra = (ic == 4'h2) || (ic == 4'h4) || (ic == 4'h6) || (ic == 4'hA);
        a_uses_sp = (ic == 4'hB) || (ic == 4'h9);
        b_uses_rb = (ic == 4'h4) || (ic == 4'h5) || (ic == 4'h6);
        b_uses_sp = (ic == 4'hA) || (ic == 4'hB) || (ic == 4'h8) || (ic == 4'h9);
        e_uses_rb = (ic == 4'h3) || (ic == 4'h6) || ((ic == 4'h2) && c);
        e_uses_sp = (ic == 4'hA) || (ic == 4'hB) || (ic == 4'h8) || (ic == 4'h9);
        m_uses_ra = (ic == 4'h5) || (ic == 4'hB);
        sa   = a_uses_ra ? ra : (a_uses_sp ? 4'h4 : 4'hF);
        sbid = b_uses_rb ? rb : (b_uses_sp ? 4'h4 : 4'hF);
        de   = e_uses_rb ? rb : (e_uses_sp ? 4'h4 : 4'hF);
        dm   = m_uses_ra ? ra : 4'hF;
    endfunction

    function automatic logic [63:0] ref_read(input logic [3:0] id);
        return (id == 4'hF) ? 64'h0 : ref_rf[id];
    endfunction

    task automatic push(input string tag, input int kind, input logic [63:0] exp);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [63:0] obs;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.kind)
                KSrcA:   obs = {60'h0, bus.srcA};
                KSrcB:   obs = {60'h0, bus.srcB};
                KDstE:   obs = {60'h0, bus.dstE};
                KDstM:   obs = {60'h0, bus.dstM};
                KValA:   obs = bus.valA;
                default: obs = bus.valB;
            endcase
            check(e.tag, obs, e.exp);
        end
    endtask

    // Apply one instruction for one cycle, check decode/read before the
    // edge, then fold the expected write-back into the model register file.
    task automatic step(input string tag, input logic [3:0] ic, input logic [3:0] ra,
                        input logic [3:0] rb, input logic c, input logic [63:0] ve,
                        input logic [63:0] vm, input logic we);
        logic [3:0] sa, sbid, de, dm;
        @(negedge clk);
        bus.icode = ic;
        bus.rA    = ra;
        bus.rB    = rb;
        bus.cnd   = c;
        bus.valE  = ve;
        bus.valM  = vm;
        bus.wb_en = we;
        model_decode(ic, ra, rb, c, sa, sbid, de, dm);
        push({tag, ".srcA"}, KSrcA, {60'h0, sa});
        push({tag, ".srcB"}, KSrcB, {60'h0, sbid});
        push({tag, ".dstE"}, KDstE, {60'h0, de});
        push({tag, ".dstM"}, KDstM, {60'h0, dm});
        push({tag, ".valA"}, KValA, ref_read(sa));
        push({tag, ".valB"}, KValB, ref_read(sbid));
        #1;
        drain();
        @(posedge clk);
        if (rst_n && we) begin
            if (de != 4'hF) ref_rf[de] = ve;
            if (dm != 4'hF) ref_rf[dm] = vm;
        end
    endtask

    // Read R[r] through both ports with a non-writing OPq.
    task automatic peek(input string tag, input logic [3:0] r);
        step(tag, 4'h6, r, r, 1'b0, 64'h0, 64'h0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 15; i++) ref_rf[i] = 64'h0;
        bus.icode = 4'h1;
        bus.rA    = 4'hF;
        bus.rB    = 4'hF;
        bus.cnd   = 1'b0;
        bus.valE  = 64'h0;
        bus.valM  = 64'h0;
        bus.wb_en = 1'b0;

        // Held in reset: reads are zero and a write edge is ignored
        step("in_reset_wr", 4'h3, 4'hF, 4'h3, 1'b0, 64'hDEAD, 64'h0, 1'b1);
        peek("in_reset_rd", 4'h3);
        #2 rst_n = 1'b1;

        // Write R[3], then asynchronous reset clears it between edges
        step("irmov_r3", 4'h3, 4'hF, 4'h3, 1'b0, 64'h1234, 64'h0, 1'b1);
        @(negedge clk);
        bus.icode = 4'h6;
        bus.rA    = 4'h3;
        bus.rB    = 4'h3;
        bus.wb_en = 1'b0;
        #1;
        push("pre_rst.valA", KValA, ref_read(4'h3));
        drain();
        rst_n = 1'b0;
        for (int i = 0; i < 15; i++) ref_rf[i] = 64'h0;
        #1;
        push("async_rst.valA", KValA, 64'h0);
        push("async_rst.srcA", KSrcA, 64'h3);
        drain();
        #1 rst_n = 1'b1;

        // irmovq then OPq, plus no write-to-read bypass
        step("irmov_r2", 4'h3, 4'hF, 4'h2, 1'b0, 64'h10, 64'h0, 1'b1);
        step("opq_r2", 4'h6, 4'h2, 4'h2, 1'b0, 64'h20, 64'h0, 1'b1);
        peek("opq_after", 4'h2);

        // popq %rsp collision: valM wins
        step("irmov_r4", 4'h3, 4'hF, 4'h4, 1'b0, 64'h100, 64'h0, 1'b1);
        step("popq_rsp", 4'hB, 4'h4, 4'hF, 1'b0, 64'h108, 64'hAA, 1'b1);
        peek("popq_after", 4'h4);

        // cmov gating
        step("cmov_nc", 4'h2, 4'h1, 4'h5, 1'b0, 64'h77, 64'h0, 1'b1);
        peek("cmov_nc_r5", 4'h5);
        step("cmov_c", 4'h2, 4'h1, 4'h5, 1'b1, 64'h77, 64'h0, 1'b1);
        peek("cmov_c_r5", 4'h5);

        // wb_en low across three edges, then halt
        for (int i = 0; i < 3; i++) begin
            step("wb_off", 4'h3, 4'hF, 4'h7, 1'b0, 64'h55, 64'h0, 1'b0);
        end
        peek("wb_off_r7", 4'h7);
        step("halt", 4'h0, 4'h3, 4'h4, 1'b1, 64'h1, 64'h2, 1'b1);

        // RNONE read/write and unknown icode
        step("mrmov_none", 4'h5, 4'hF, 4'hF, 1'b0, 64'h9, 64'h99, 1'b1);
        step("icode_c", 4'hC, 4'h1, 4'h2, 1'b1, 64'h3, 64'h4, 1'b1);
        peek("none_r2", 4'h2);
        peek("none_r4", 4'h4);

        // Randomized sweep against the model
        for (int i = 0; i < 48; i++) begin
            step("rand", 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 {$urandom, $urandom}, {$urandom, $urandom}, ($urandom_range(0, 3) != 0));
        end
        for (int r = 0; r < 15; r++) begin
            peek("final_rd", 4'(r));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/decode_writeback.md
# decode_writeback

Register-file stage for the sequential Y86-64 core. It sits directly downstream of instruction fetch. It decodes fetch's icode/rA/rB into source and destination register IDs, and reads operands valA/valB from a 15-entry, 64-bit register file. On each clock edge it writes back valE/valM computed by later stages of the same instruction.

## Interface
Parameters:
- WIDTH, 64, register and data width
- RSP_ID, 4'h4, register ID of %rsp used by stack instructions
- RNONE, 4'hF, "no register" ID; reads return 0, writes are dropped

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  core clock, all state changes on posedge
- rst_n  in  1  asynchronous active-low reset
- icode  in  4  instruction code from fetch
- rA  in  4  register A field from fetch
- rB  in  4  register B field from fetch
- cnd  in  1  condition result from execute; gates cmovXX writes
- valE  in  WIDTH  execute result to write to dstE
- valM  in  WIDTH  memory read result to write to dstM
- wb_en  in  1  write-back enable; low on halt, invalid instruction, or memory error
- srcA  out  4  decoded source A ID
- srcB  out  4  decoded source B ID
- dstE  out  4  decoded E destination ID, after cnd gating
- dstM  out  4  decoded M destination ID
- valA  out  WIDTH  R[srcA], or 0 when srcA==RNONE
- valB  out  WIDTH  R[srcB], or 0 when srcB==RNONE

## Operation
- Storage: registers R[0..14], each WIDTH bits. ID 15 is not storage.
- srcA decode:
  - rA for cmovXX (2), rmmovq (4), OPq (6), pushq (A)
  - RSP_ID for popq (B) and ret (9)
  - RNONE otherwise
- srcB decode:
  - rB for rmmovq, mrmovq (5), OPq
  - RSP_ID for pushq, popq, call (8), ret
  - RNONE otherwise
- dstE decode:
  - rB for irmovq (3) and OPq
  - rB for cmovXX when cnd=1; RNONE when cnd=0
  - RSP_ID for pushq, popq, call, ret
  - RNONE otherwise
- dstM decode: rA for mrmovq and popq; RNONE otherwise.
- Unknown icode (>4'hB), halt (0), nop (1), jXX (7): all four IDs are RNONE.
- Reads are combinational from current register contents.
- Write-back happens at posedge clk when wb_en=1:
  - R[dstE] ← valE if dstE≠RNONE
  - R[dstM] ← valM if dstM≠RNONE
- Write collision (dstE==dstM, e.g. popq %rsp): valM wins and valE is discarded.
- wb_en=0: no register changes. Decode outputs still track the inputs.

## Timing
- Decode outputs and valA/valB are combinational; zero-cycle latency from icode/rA/rB.
- Writes take effect at the posedge. A read in the same cycle as a write returns the old value (no write-to-read bypass). The new value is visible after the edge.
- Reset: asserting rst_n=0 clears R[0..14] to 0 immediately, without waiting for clk. valA/valB therefore read 0 while in reset.
- Decode outputs are not stored, so they are unaffected by reset.
- A write edge that coincides with rst_n low is ignored. Reset dominates.
- Deassertion is synchronized externally. The first write can occur on the first posedge with rst_n=1.

## Test plan
- Reset clear: write 0x1234 to R[3], pulse rst_n low between edges → valA=0 with icode=6, rA=3, immediately and without a clock edge.
- irmovq then OPq:
  - Cycle 1: icode=3, rB=2, valE=0x10, wb_en=1.
  - Cycle 2: icode=6, rA=2, rB=2 → srcA=srcB=2, valA=valB=0x10, dstE=2.
- popq %rsp collision: R[4]=0x100, icode=B, rA=4, valE=0x108, valM=0xAA → after the edge R[4]=0xAA; srcA=srcB=4 before the edge.
- cmov gating:
  - icode=2, rA=1, rB=5, cnd=0, valE=0x77 → dstE=F, R[5] unchanged.
  - Repeat with cnd=1 → R[5]=0x77.
- wb_en low: icode=3, rB=7, valE=0x55, wb_en=0 → R[7] unchanged across 3 edges. Halt icode=0 gives all IDs = F.
- RNONE read/write: icode=5 (mrmovq) with rB=F, rA=F → valB=0, dstM=F, no register modified; icode=C → all IDs F.
